// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU INOp codes, R-type func codes,
// forwarding-select encoding and default widths.
package id_ex_stage_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_AW = 5;

    typedef enum logic [1:0] {
        INOP_PUSH_ADD = 2'd0,
        INOP_PUSH_SUB = 2'd1,
        INOP_DIAG     = 2'd2,
        INOP_NOP      = 2'd3
    } inop_t;

    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;
    localparam logic [5:0] FUNC_SLT = 6'h2a;
    localparam logic [5:0] FUNC_JR  = 6'h08;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding mux: EX/MEM beats MEM/WB, register $0 is never forwarded.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_wdata,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] operand
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_REG;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src))
            sel = FWD_EXMEM;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src))
            sel = FWD_MEMWB;
    end

    always_comb begin
        operand = reg_data;
        case (sel)
            FWD_EXMEM: operand = exmem_res;
            FWD_MEMWB: operand = memwb_wdata;
            default:   operand = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALUSrc mux and
// load-use hazard detection (one-cycle stall plus bubble).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [5:0]        id_func,
    input  logic [1:0]        id_inop,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_inop,
    output logic [5:0]        alu_func,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg
);

    logic              ex_valid;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_imm;
    logic              ex_alusrc;
    inop_t             ex_inop;
    logic [5:0]        ex_func;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // A load in EX whose target the instruction in ID reads cannot be forwarded in time.
    assign stall = ex_valid & ex_memread & (ex_rt != '0) & id_valid
                 & ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_alusrc   <= 1'b0;
            ex_inop     <= INOP_NOP;
            ex_func     <= '0;
            ex_dst      <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
        end else if (flush || stall) begin
            // Bubble: only valid and side-effecting control are cleared; data fields hold.
            ex_valid    <= 1'b0;
            ex_inop     <= INOP_NOP;
            ex_func     <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_a        <= id_a;
            ex_b        <= id_b;
            ex_imm      <= id_imm;
            ex_alusrc   <= id_alusrc;
            ex_inop     <= inop_t'(id_inop);
            ex_func     <= id_func;
            ex_dst      <= id_regdst ? id_rd : id_rt;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_memtoreg <= id_memtoreg;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src            (ex_rs),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_res      (exmem_res),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_wdata    (memwb_wdata),
        .reg_data       (ex_a),
        .operand        (fwd_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src            (ex_rt),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_res      (exmem_res),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_wdata    (memwb_wdata),
        .reg_data       (ex_b),
        .operand        (fwd_b)
    );

    assign alu_a         = fwd_a;
    assign ex_store_data = fwd_b;
    assign alu_b         = ex_alusrc ? ex_imm : fwd_b;
    assign alu_inop      = ex_inop;
    assign alu_func      = ex_func;

endmodule
